// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers and MTHI/MTLO.
// Define MD_EARLY_OUT_EN to finish multiplies early on short multipliers and divides early on b==0.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;    // product accumulator
    logic [2*WIDTH-1:0]   opd_q, opd_d;    // shifting multiplicand, or dividend/quotient in low half
    logic [WIDTH-1:0]     dsr_q, dsr_d;    // shifting multiplier, or divisor
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d, dzo_q, dzo_d;

    logic                 sgn;
    logic [WIDTH-1:0]     a_mag, b_mag, quo, rmd;
    logic [WIDTH+1:0]     rem_sh;
    logic [WIDTH:0]       rem_sub;
    logic [2*WIDTH-1:0]   fix_prod;
    logic                 last_iter;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            a_q       <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dzo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opd_q     <= opd_d;
            dsr_q     <= dsr_d;
            rem_q     <= rem_d;
            a_q       <= a_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dzo_q     <= dzo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opd_d     = opd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        a_d       = a_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dzo_d     = 1'b0;
        sgn       = ~op[0];
        a_mag     = (sgn && a[WIDTH-1]) ? -a : a;
        b_mag     = (sgn && b[WIDTH-1]) ? -b : b;
        rem_sh    = {rem_q, opd_q[WIDTH-1]};
        rem_sub   = rem_sh[WIDTH:0] - {1'b0, dsr_q};
        quo       = opd_q[WIDTH-1:0];
        rmd       = rem_q[WIDTH-1:0];
        fix_prod  = neg_q ? -acc_q : acc_q;
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    case (op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            is_div_d  = op[1];
                            neg_d     = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                            rem_neg_d = sgn & a[WIDTH-1];
                            dz_d      = (b == '0);
                            a_d       = a;
                            opd_d     = {{WIDTH{1'b0}}, a_mag};
                            dsr_d     = b_mag;
                            acc_d     = '0;
                            rem_d     = '0;
                            cnt_d     = '0;
                            state_d   = RUN;
                        end
                        3'd4:    hi_d = a;
                        3'd5:    lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    if (!is_div_q) begin
                        if (dsr_q[0]) acc_d = acc_q + opd_q;
                        opd_d = opd_q << 1;
                        dsr_d = dsr_q >> 1;
                    end else if (rem_sh >= {2'b00, dsr_q}) begin
                        rem_d = rem_sub;
                        opd_d = {opd_q[2*WIDTH-1:WIDTH], opd_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[WIDTH:0];
                        opd_d = {opd_q[2*WIDTH-1:WIDTH], opd_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
`ifdef MD_EARLY_OUT_EN
                    if (last_iter || (!is_div_q && (dsr_q >> 1) == '0) || (is_div_q && dz_q))
                        state_d = FIX;
`else
                    if (last_iter) state_d = FIX;
`endif
                end
            end
            FIX: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = fix_prod[2*WIDTH-1:WIDTH];
                        lo_d = fix_prod[WIDTH-1:0];
                    end else if (dz_q) begin
                        // Divide by zero: quotient saturates to all ones, HI keeps the raw dividend
                        lo_d  = '1;
                        hi_d  = a_q;
                        dzo_d = 1'b1;
                    end else begin
                        lo_d = neg_q ? -quo : quo;
                        hi_d = rem_neg_q ? -rmd : rmd;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dzo_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic reference model checked every cycle plus literal pins.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         flush;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;
  logic cmp_en = 1'b0;

`ifdef MD_EARLY_OUT_EN
  localparam int DZ_LAT = 2;
`else
  localparam int DZ_LAT = 33;
`endif

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // reference arithmetic: returns {div_by_zero, hi, lo}
  function automatic logic [2*W:0] md_ref(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    logic [2*W:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = '0;
    case (o)
      3'd0: begin p = sx * sy; res = {1'b0, p}; end
      3'd1: begin p = {32'b0, x} * {32'b0, y}; res = {1'b0, p}; end
      default: begin
        if (y == 0) res = {1'b1, x, {W{1'b1}}};
        else if (o == 3'd2) begin q = sx / sy; r = sx % sy; res = {1'b0, r[W-1:0], q[W-1:0]}; end
        else res = {1'b0, x % y, x / y};
      end
    endcase
    return res;
  endfunction

  function automatic int lat_of(input logic [2:0] o, input logic [W-1:0] y);
    int k;
    logic [W-1:0] mag;
    lat_of = W + 1;
`ifdef MD_EARLY_OUT_EN
    if (o <= 3'd1) begin
      mag = (o == 3'd0 && y[W-1]) ? -y : y;
      k = 0;
      for (int i = 0; i < W; i++) if (mag[i]) k = i + 1;
      if (k < 1) k = 1;
      lat_of = k + 1;
    end else if (y == 0) lat_of = 2;
`endif
  endfunction

  // behavioural model: HI/LO and a pending operation with a remaining-edge count
  logic [W-1:0] m_hi, m_lo, r_hi, r_lo;
  logic         m_done, m_dz, m_pend, r_dz;
  int           m_rem;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_dz <= 1'b0; m_pend <= 1'b0; m_rem <= 0;
    end else begin
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      if (m_pend) begin
        if (flush) m_pend <= 1'b0;
        else if (m_rem == 1) begin
          m_hi <= r_hi; m_lo <= r_lo; m_done <= 1'b1; m_dz <= r_dz; m_pend <= 1'b0;
        end else m_rem <= m_rem - 1;
      end else if (start && !flush) begin
        if (op <= 3'd3) begin
          {r_dz, r_hi, r_lo} <= md_ref(op, a, b);
          m_rem  <= lat_of(op, b);
          m_pend <= 1'b1;
        end else if (op == 3'd4) m_hi <= a;
        else if (op == 3'd5) m_lo <= a;
      end
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_hi", {32'b0, hi}, {32'b0, m_hi});
      chk("cyc_lo", {32'b0, lo}, {32'b0, m_lo});
      chk("cyc_busy", {63'b0, busy}, {63'b0, m_pend});
      chk("cyc_done", {63'b0, done}, {63'b0, m_done});
      chk("cyc_dz", {63'b0, div_by_zero}, {63'b0, m_dz});
    end
  end

  // driver: issue one op and wait (bounded) for done, then pin literal results
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] e_hi, input logic [W-1:0] e_lo, input logic e_dz,
                        input int e_lat);
    int n, busy_cnt;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    n = 1; busy_cnt = 0;
    while (!done && n < 200) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    chk("done_seen", {63'b0, done}, 64'd1);
    if (done) begin
      chk("lit_hi", {32'b0, hi}, {32'b0, e_hi});
      chk("lit_lo", {32'b0, lo}, {32'b0, e_lo});
      chk("lit_dz", {63'b0, div_by_zero}, {63'b0, e_dz});
      chk("lit_busy_cycles", 64'(busy_cnt), 64'(e_lat));
      chk("busy_low_at_done", {63'b0, busy}, 64'd0);
    end
  endtask

  task automatic move(input logic [2:0] o, input logic [W-1:0] av);
    @(negedge clk);
    start = 1'b1; op = o; a = av;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int done_cnt;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    rst = 1'b0;
    cmp_en = 1'b1;

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, lat_of(3'd0, 32'd7));
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 33);
    run_op(3'd2, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33);
    run_op(3'd2, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b1, DZ_LAT);
    run_op(3'd3, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1, DZ_LAT);
    run_op(3'd0, 32'd6, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0, lat_of(3'd0, 32'hFFFF_FFFE));
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33);

    // moves, and a reserved op that must change nothing
    move(3'd4, 32'h1111_2222);
    chk("mthi", {32'b0, hi}, 64'h1111_2222);
    move(3'd5, 32'h3333_4444);
    chk("mtlo", {32'b0, lo}, 64'h3333_4444);
    move(3'd6, 32'h5555_6666);
    chk("rsvd_hi", {32'b0, hi}, 64'h1111_2222);
    chk("rsvd_busy", {63'b0, busy}, 64'd0);

    // flush mid-RUN; a start at cycle 5 is ignored
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd12345; b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 10; n++) begin
      if (n == 4) begin start = 1'b1; op = 3'd4; a = 32'hBAD0_BAD0; end
      else start = 1'b0;
      @(negedge clk);
      if (done) done_cnt++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'b0, busy}, 64'd0);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("flush_no_done", 64'(done_cnt), 64'd0);
    chk("flush_hi_kept", {32'b0, hi}, 64'h1111_2222);
    chk("flush_lo_kept", {32'b0, lo}, 64'h3333_4444);

    // flush together with start in IDLE discards the start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'h7777_7777;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("start_flush_hi", {32'b0, hi}, 64'h1111_2222);

    // asynchronous reset between edges during RUN
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd999; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_hi", {32'b0, hi}, 64'd0);
    chk("async_rst_lo", {32'b0, lo}, 64'd0);
    chk("async_rst_busy", {63'b0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    move(3'd4, 32'h0000_CAFE);
    chk("post_rst_mthi", {32'b0, hi}, 64'hCAFE);
    chk("post_rst_lo", {32'b0, lo}, 64'd0);
    chk("post_rst_busy", {63'b0, busy}, 64'd0);
    chk("post_rst_done", {63'b0, done}, 64'd0);

    // back-to-back: new start issued in the done cycle
    run_op(3'd1, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, lat_of(3'd1, 32'd5));
    start = 1'b1; op = 3'd3; a = 32'd50; b = 32'd8;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {63'b0, busy}, 64'd1);
    repeat (40) @(negedge clk);
    chk("b2b_lo", {32'b0, lo}, 64'd6);
    chk("b2b_hi", {32'b0, hi}, 64'd2);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
